// File: rtl/vtg_pkg.sv
// vtg_pkg: axis timing record, 1024x768 defaults and raster helper functions
package vtg_pkg;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vtg_axis_t;
  localparam vtg_axis_t VTG_1024x768_H = '{active: 1024, fp: 24, sync: 136, bp: 160};
  localparam vtg_axis_t VTG_1024x768_V = '{active: 768, fp: 3, sync: 6, bp: 29};
  function automatic int vtg_total(vtg_axis_t t);
    return t.sync + t.bp + t.active + t.fp;
  endfunction
  function automatic logic vtg_in_active(vtg_axis_t t, int p);
    return p >= t.sync + t.bp && p < t.sync + t.bp + t.active;
  endfunction
endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis; position plus sync/active flags registered alongside it
module vtg_axis_counter import vtg_pkg::*; #(
  parameter int LEN_W = 11,
  parameter vtg_axis_t T = VTG_1024x768_H
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  output logic [LEN_W-1:0] pos,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);
  // one extra bit so window ends equal to 2**LEN_W still compare correctly
  localparam logic [LEN_W:0] LAST  = (LEN_W+1)'(vtg_total(T) - 1);
  localparam logic [LEN_W:0] SYNC_E = (LEN_W+1)'(T.sync);
  localparam logic [LEN_W:0] ACT_S = (LEN_W+1)'(T.sync + T.bp);
  localparam logic [LEN_W:0] ACT_E = (LEN_W+1)'(T.sync + T.bp + T.active);
  logic [LEN_W-1:0] pos_q, pos_d;
  logic [LEN_W:0]   p;
  logic             sync_q, act_q;
  always_comb begin
    wrap  = en && {1'b0, pos_q} == LAST;
    pos_d = rst ? '0 : wrap ? '0 : en ? pos_q + 1'b1 : pos_q;
    p     = {1'b0, pos_d};
  end
  always_ff @(posedge clock) begin
    pos_q  <= pos_d;
    sync_q <= p < SYNC_E;
    act_q  <= p >= ACT_S && p < ACT_E;
  end
  assign pos       = pos_q;
  assign in_sync   = sync_q;
  assign in_active = act_q;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator advancing on pix_en ticks
// VTG_PREFETCH_EN adds next_x/next_y/next_valid for a 1-tick-latency framebuffer read
module video_timing_gen import vtg_pkg::*; #(
  parameter int H_ACTIVE  = VTG_1024x768_H.active,
  parameter int H_FP      = VTG_1024x768_H.fp,
  parameter int H_SYNC    = VTG_1024x768_H.sync,
  parameter int H_BP      = VTG_1024x768_H.bp,
  parameter int V_ACTIVE  = VTG_1024x768_V.active,
  parameter int V_FP      = VTG_1024x768_V.fp,
  parameter int V_SYNC    = VTG_1024x768_V.sync,
  parameter int V_BP      = VTG_1024x768_V.bp,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           pix_en,
  output logic [X_W-1:0] beam_x,
  output logic [Y_W-1:0] beam_y,
  output logic           valid,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
`ifdef VTG_PREFETCH_EN
  ,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output logic           next_valid
`endif
);
  localparam vtg_axis_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vtg_axis_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  if ((64'd1 << X_W) < 64'(vtg_total(HT))) begin : g_xw_chk
    $error("X_W too narrow for H_TOTAL");
  end
  if ((64'd1 << Y_W) < 64'(vtg_total(VT))) begin : g_yw_chk
    $error("Y_W too narrow for V_TOTAL");
  end
  logic h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  vtg_axis_counter #(.LEN_W(X_W), .T(HT)) u_h (
    .clock(clock), .rst(rst), .en(pix_en),
    .pos(beam_x), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
  );
  vtg_axis_counter #(.LEN_W(Y_W), .T(VT)) u_v (
    .clock(clock), .rst(rst), .en(pix_en & h_wrap),
    .pos(beam_y), .wrap(v_wrap), .in_sync(v_sync), .in_active(v_act)
  );
  always_comb begin
    line_start_d  = ~rst & h_wrap;
    frame_start_d = ~rst & v_wrap;
  end
  always_ff @(posedge clock) begin
    line_start_q  <= line_start_d;
    frame_start_q <= frame_start_d;
  end
  assign valid       = h_act & v_act;
  assign hsync       = h_sync ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = v_sync ? VSYNC_POL : ~VSYNC_POL;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VTG_PREFETCH_EN
  localparam logic [X_W-1:0] H_LAST = X_W'(vtg_total(HT) - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(vtg_total(VT) - 1);
  always_comb begin
    next_x     = beam_x == H_LAST ? '0 : beam_x + 1'b1;
    next_y     = beam_x != H_LAST ? beam_y : beam_y == V_LAST ? '0 : beam_y + 1'b1;
    next_valid = vtg_in_active(HT, int'(next_x)) && vtg_in_active(VT, int'(next_y));
  end
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: default 1024x768 and tiny raster instances checked against a tick-count model
module tb_video_timing_gen;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clock = ~clock;

  logic [10:0] dx; logic [9:0] dy; logic dv, dh, dvs, dls, dfs;
  logic [2:0] sx, sy; logic sv, sh, svs, sls, sfs;
`ifdef VTG_PREFETCH_EN
  logic [10:0] dnx; logic [9:0] dny; logic dnv;
  logic [2:0] snx, sny; logic snv;
`endif

  video_timing_gen u_def (
    .clock(clock), .rst(rst), .pix_en(pix_en),
    .beam_x(dx), .beam_y(dy), .valid(dv), .hsync(dh), .vsync(dvs),
    .line_start(dls), .frame_start(dfs)
`ifdef VTG_PREFETCH_EN
    , .next_x(dnx), .next_y(dny), .next_valid(dnv)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .X_W(3), .Y_W(3)
  ) u_small (
    .clock(clock), .rst(rst), .pix_en(pix_en),
    .beam_x(sx), .beam_y(sy), .valid(sv), .hsync(sh), .vsync(svs),
    .line_start(sls), .frame_start(sfs)
`ifdef VTG_PREFETCH_EN
    , .next_x(snx), .next_y(sny), .next_valid(snv)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n = 0;
  bit t = 1'b0;

  function automatic logic [39:0] expv(int k, bit tk, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb, bit hp, bit vp);
    int ht = hs + hb + ha + hf;
    int vt = vs + vb + va + vf;
    int x = k % ht;
    int y = (k / ht) % vt;
    bit val = x >= hs + hb && x < hs + hb + ha && y >= vs + vb && y < vs + vb + va;
    bit h = x < hs ? hp : !hp;
    bit v = y < vs ? vp : !vp;
    bit ls = tk && x == 0;
    bit fs = ls && y == 0;
    return {16'(x), 16'(y), 3'b0, val, h, v, ls, fs};
  endfunction

  function automatic logic [39:0] expd(int k, bit tk);
    return expv(k, tk, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
  endfunction
  function automatic logic [39:0] exps(int k, bit tk);
    return expv(k, tk, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);
  endfunction

  logic [39:0] obs_d, obs_s;
  assign obs_d = {5'b0, dx, 6'b0, dy, 3'b0, dv, dh, dvs, dls, dfs};
  assign obs_s = {13'b0, sx, 13'b0, sy, 3'b0, sv, sh, svs, sls, sfs};

  task automatic cyc(input bit r, input bit e);
    rst = r;
    pix_en = e;
    @(posedge clock);
    if (r) begin n = 0; t = 1'b0; end
    else begin t = e; if (e) n++; end
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    checks++;
    if (obs_d !== expd(n, t)) begin failures++; $display("FAIL reset_def act=%h req=%h", obs_d, expd(n, t)); end
    checks++;
    if (obs_s !== exps(n, t)) begin failures++; $display("FAIL reset_small act=%h req=%h", obs_s, exps(n, t)); end
    checks++;
    if ({dh, dvs, sh, svs} !== 4'b0010) begin failures++; $display("FAIL reset_sync act=%b req=0010", {dh, dvs, sh, svs}); end
  endtask

  task automatic test_line;
    int hlow = 0, lines = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 2688; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (obs_d !== expd(n, t)) begin failures++; $display("FAIL line_def n=%0d act=%h req=%h", n, obs_d, expd(n, t)); end
      hlow += (dh == 1'b0);
      lines += dls;
    end
    checks++;
    if (hlow != 272) begin failures++; $display("FAIL line_hsync_low act=%0d req=272", hlow); end
    checks++;
    if (lines != 2) begin failures++; $display("FAIL line_starts act=%0d req=2", lines); end
  endtask

  task automatic test_small_frames;
    int frames = 0, vis = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 144; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (obs_s !== exps(n, t)) begin failures++; $display("FAIL small n=%0d act=%h req=%h", n, obs_s, exps(n, t)); end
      frames += sfs;
      vis += sv;
    end
    checks++;
    if (frames != 3) begin failures++; $display("FAIL small_frames act=%0d req=3", frames); end
    checks++;
    if (vis != 36) begin failures++; $display("FAIL small_valid act=%0d req=36", vis); end
  endtask

  task automatic test_toggle;
    int hlow = 0, lines = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5376; i++) begin
      cyc(1'b0, i % 2 == 0);
      checks++;
      if (obs_d !== expd(n, t)) begin failures++; $display("FAIL toggle_def n=%0d act=%h req=%h", n, obs_d, expd(n, t)); end
      checks++;
      if (obs_s !== exps(n, t)) begin failures++; $display("FAIL toggle_small n=%0d act=%h req=%h", n, obs_s, exps(n, t)); end
      hlow += (dh == 1'b0);
      lines += dls;
    end
    checks++;
    if (hlow != 544) begin failures++; $display("FAIL toggle_hsync_low act=%0d req=544", hlow); end
    checks++;
    if (lines != 2) begin failures++; $display("FAIL toggle_line_starts act=%0d req=2", lines); end
  endtask

  task automatic test_rst_mid;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 2044; i++) cyc(1'b0, 1'b1);
    checks++;
    if ({dx, dy} !== {11'd700, 10'd1}) begin failures++; $display("FAIL rst_mid_pos act=%0d,%0d req=700,1", dx, dy); end
    cyc(1'b1, 1'b1);
    checks++;
    if ({dx, dy, dv, dh, dvs, dls, dfs} !== 26'd0) begin
      failures++; $display("FAIL rst_mid act=%0d,%0d v=%b h=%b vs=%b req=0,0 v=0 h=0 vs=0", dx, dy, dv, dh, dvs);
    end
    checks++;
    if (obs_s !== exps(n, t)) begin failures++; $display("FAIL rst_mid_small act=%h req=%h", obs_s, exps(n, t)); end
  endtask

  task automatic test_random;
    logic [39:0] e;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (obs_d !== expd(n, t)) begin failures++; $display("FAIL rand_def n=%0d act=%h req=%h", n, obs_d, expd(n, t)); end
      checks++;
      if (obs_s !== exps(n, t)) begin failures++; $display("FAIL rand_small n=%0d act=%h req=%h", n, obs_s, exps(n, t)); end
`ifdef VTG_PREFETCH_EN
      e = expd(n + 1, 1'b0);
      checks++;
      if ({5'b0, dnx, 6'b0, dny, dnv} !== {e[39:8], e[4]}) begin
        failures++; $display("FAIL prefetch_def n=%0d act=%0d,%0d,%b req=%h", n, dnx, dny, dnv, e);
      end
      e = exps(n + 1, 1'b0);
      checks++;
      if ({13'b0, snx, 13'b0, sny, snv} !== {e[39:8], e[4]}) begin
        failures++; $display("FAIL prefetch_small n=%0d act=%0d,%0d,%b req=%h", n, snx, sny, snv, e);
      end
`else
      e = '0;
`endif
    end
  endtask

  initial begin
    test_reset;
    test_line;
    test_small_frames;
    test_toggle;
    test_rst_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
